la_axis_capture: RTL and testbench
==================================

Name: la_axis_capture

Overview:
- Logic-analyzer capture front end that feeds the switch's LA upstream port (la_as_* / la_hpri_req / as_la_tready).
- Samples a probe bus every clock and records only changes, tagging each with an 8-bit elapsed-cycle delta.
- Buffers records in a small register FIFO and emits them as a framed AXI-Stream.
- Raises a high-priority request when buffer occupancy crosses a threshold.

Parameters:
- pDATA_WIDTH, 32, stream data width; fixed at 32.
- pPROBE_WIDTH, 24, probe bits captured; pPROBE_WIDTH + 8 = pDATA_WIDTH.
- pFIFO_DEPTH, 8, record buffer depth; power of two.
- pFRAME_LEN, 16, maximum words per frame before tlast is forced.
- pHPRI_TH, 6, occupancy at or above which la_hpri_req asserts.

Ports:
- axis_clk  in  1  single clock for the whole block
- axis_rst  in  1  asynchronous, active-high reset
- la_en  in  1  capture enable, level
- la_probe  in  pPROBE_WIDTH  probe bus, synchronous to axis_clk
- la_as_tdata  out  pDATA_WIDTH  {delta[7:0], probe[pPROBE_WIDTH-1:0]}
- la_as_tstrb  out  pDATA_WIDTH/8  constant all-ones
- la_as_tkeep  out  pDATA_WIDTH/8  constant all-ones
- la_as_tlast  out  1  end of frame
- la_as_tvalid  out  1  FIFO head valid
- la_as_tuser  out  2  constant 2'b00
- la_hpri_req  out  1  high-priority request to the arbiter
- as_la_tready  in  1  ready from the switch
- la_ovf  out  1  sticky overflow flag
- la_drop_cnt  out  8  dropped-record count, saturating

Behaviour:

Reset (axis_rst=1, async):
- FIFO empty; tvalid=0, tlast=0, hpri_req=0, ovf=0, drop_cnt=0.
- tdata=0; prev_probe=0; delta=0; frame_cnt=0; armed=0.
- Reset mid-frame discards all buffered records. There is no partial-frame completion.

Capture:
- Registered stage; one cycle from probe change to push.
- armed sets on the first la_en=1 cycle and clears when la_en=0.
- First armed cycle: push an unconditional record with delta=0.
- Each later armed cycle where la_probe != prev_probe: push {delta, la_probe}.
- prev_probe <= la_probe every cycle.
- delta counter: clears to 0 on each push, otherwise increments each cycle, saturating at 8'hFF (no wrap).
- While la_en=0: no pushes and delta holds 0.

FIFO:
- Pointers carry one extra MSB for full/empty detection. level = wptr - rptr, range 0..pFIFO_DEPTH.
- pop = la_as_tvalid & as_la_tready.
- Push and pop in the same cycle are both honoured, including when full (level unchanged).
- Push while full without a pop: record dropped, la_ovf <= 1, drop_cnt += 1 (saturating at 255).
- la_ovf and drop_cnt clear only on a la_en rising edge (or reset).
- la_as_tvalid = (level != 0). The head word is held stable while tvalid=1 & tready=0 (AXIS rule).

Framing:
- frame_cnt counts popped words.
- la_as_tlast = tvalid & ((frame_cnt == pFRAME_LEN-1) | (la_en==0 & level==1)).
- frame_cnt resets to 0 on a popped tlast word, otherwise increments on pop.
- Disabling capture therefore flushes the buffer and terminates the frame on the last buffered word.

Priority:
- la_hpri_req registered: <= (level_next >= pHPRI_TH).
- It deasserts the cycle after level drops below threshold.

Decomposition:
- Shared package: record field offsets (DELTA_OFFSET = pPROBE_WIDTH), TUSER_LA = 2'b00, DELTA_MAX = 8'hFF.
- One natural sub-module, la_rec_fifo: a parameterized register FIFO with push/pop/level/full/empty outputs.
- Capture, delta, framing and overflow logic stay in the top module.

Test Plan:
- Enable, probe held at 0x000000, tready=1: exactly one word 0x00000000. It carries tlast once la_en drops with level==1. No further words.
- Probe changes at cycles 0, 3, 300 after arming: words with delta 0x00, 0x03, 0xFF (saturated). Probe fields match.
- tready=0 with 10 changes at pFIFO_DEPTH=8: level reaches 8, la_hpri_req=1 from level 6. la_ovf=1, drop_cnt=2. Releasing tready drains 8 words in order.
- Continuous change every cycle for 40 cycles, tready=1: tlast on words 16 and 32. Final word tlast after la_en deasserts. No drops.
- Full FIFO with a simultaneous push and pop: level stays 8, no drop, ovf unchanged.
- axis_rst pulse mid-frame with level=5: tvalid=0 immediately (async). After release, a new enable starts a fresh frame with frame_cnt=0.

Source files
------------

// File: rtl/la_axis_capture_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : la_axis_capture_pkg
//  Purpose  : Shared record layout constants and helpers for the logic-analyzer
//             capture front end.
//  Revision : 1.0 - initial release
// ============================================================================
package la_axis_capture_pkg;

    // Record layout: {delta[7:0], probe[PROBE_WIDTH-1:0]}
    localparam int          PROBE_WIDTH  = 24;
    localparam int          DELTA_WIDTH  = 8;
    localparam int          DELTA_OFFSET = PROBE_WIDTH;

    // Sideband value presented on tuser for every LA word
    localparam logic [1:0]  TUSER_LA     = 2'b00;

    // Elapsed-cycle delta saturates here instead of wrapping
    localparam logic [DELTA_WIDTH-1:0] DELTA_MAX = 8'hFF;

    // Saturating increment for the delta counter
    function automatic logic [DELTA_WIDTH-1:0] delta_sat_inc(input logic [DELTA_WIDTH-1:0] d);
        return (d == DELTA_MAX) ? d : d + 8'd1;
    endfunction

endpackage : la_axis_capture_pkg
`default_nettype wire

// File: rtl/la_rec_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : la_rec_fifo
//  Purpose  : Small register FIFO for capture records. Pointers carry one
//             extra MSB so level spans 0..pDEPTH. A push into a full FIFO is
//             accepted only if a pop happens in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module la_rec_fifo #(
    parameter int pWIDTH = 32,
    parameter int pDEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [pWIDTH-1:0]           data_i,
    input  logic                        pop_i,
    output logic [pWIDTH-1:0]           data_o,
    output logic [$clog2(pDEPTH):0]     level_o,
    output logic [$clog2(pDEPTH):0]     level_next_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int                ADDR_W     = $clog2(pDEPTH);
    localparam logic [ADDR_W:0]   FULL_LEVEL = (ADDR_W+1)'(pDEPTH);

    logic [pWIDTH-1:0]  mem_q [pDEPTH];
    logic [ADDR_W:0]    wptr_q;
    logic [ADDR_W:0]    rptr_q;

    logic               w_push_ok;
    logic               w_pop_ok;
    logic [ADDR_W:0]    w_level;

    assign w_level      = wptr_q - rptr_q;
    assign empty_o      = (w_level == '0);
    assign full_o       = (w_level == FULL_LEVEL);
    assign w_pop_ok     = pop_i & ~empty_o;
    // A pop frees the slot being written, so full+pop still accepts the push
    assign w_push_ok    = push_i & (~full_o | w_pop_ok);
    assign level_o      = w_level;
    assign level_next_o = w_level + {{ADDR_W{1'b0}}, w_push_ok} - {{ADDR_W{1'b0}}, w_pop_ok};
    // Head word is a direct read so it stays stable until popped
    assign data_o       = mem_q[rptr_q[ADDR_W-1:0]];

    // Storage array; cleared on reset so the head reads zero when empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < pDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (w_push_ok) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= data_i;
        end
    end

    // Read and write pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (w_push_ok) wptr_q <= wptr_q + 1'b1;
            if (w_pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule : la_rec_fifo
`default_nettype wire

// File: rtl/la_axis_capture.sv
`default_nettype none
// ============================================================================
//  Module   : la_axis_capture
//  Purpose  : Logic-analyzer capture front end. Records probe-bus changes
//             tagged with an 8-bit elapsed-cycle delta, buffers them and
//             emits them as a framed AXI-Stream toward the switch. Raises a
//             high-priority request when the buffer fills past a threshold.
//  Revision : 1.0 - initial release
// ============================================================================
module la_axis_capture
    import la_axis_capture_pkg::*;
#(
    parameter int pDATA_WIDTH  = 32,
    parameter int pPROBE_WIDTH = PROBE_WIDTH,
    parameter int pFIFO_DEPTH  = 8,
    parameter int pFRAME_LEN   = 16,
    parameter int pHPRI_TH     = 6
) (
    input  logic                      axis_clk,
    input  logic                      axis_rst,
    input  logic                      la_en,
    input  logic [pPROBE_WIDTH-1:0]   la_probe,
    output logic [pDATA_WIDTH-1:0]    la_as_tdata,
    output logic [pDATA_WIDTH/8-1:0]  la_as_tstrb,
    output logic [pDATA_WIDTH/8-1:0]  la_as_tkeep,
    output logic                      la_as_tlast,
    output logic                      la_as_tvalid,
    output logic [1:0]                la_as_tuser,
    output logic                      la_hpri_req,
    input  logic                      as_la_tready,
    output logic                      la_ovf,
    output logic [7:0]                la_drop_cnt
);

    localparam int                LVL_W   = $clog2(pFIFO_DEPTH) + 1;
    localparam int                FCNT_W  = (pFRAME_LEN > 1) ? $clog2(pFRAME_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(pFRAME_LEN - 1);
    localparam logic [LVL_W-1:0]  HPRI_LVL  = LVL_W'(pHPRI_TH);
    localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);

    // Registered state
    logic                      armed_q,     armed_d;
    logic [pPROBE_WIDTH-1:0]   prev_probe_q;
    logic [DELTA_WIDTH-1:0]    delta_q,     delta_d;
    logic [FCNT_W-1:0]         frame_cnt_q, frame_cnt_d;
    logic                      ovf_q,       ovf_d;
    logic [7:0]                drop_cnt_q,  drop_cnt_d;
    logic                      hpri_q,      hpri_d;

    // Combinational
    logic                      w_en_rise;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_drop;
    logic                      w_tlast;
    logic [DELTA_WIDTH-1:0]    w_rec_delta;
    logic [pDATA_WIDTH-1:0]    w_rec;
    logic [pDATA_WIDTH-1:0]    w_head;
    logic [LVL_W-1:0]          w_level;
    logic [LVL_W-1:0]          w_level_next;
    logic                      w_full;
    logic                      w_empty;

    // The first enabled cycle always records, even without a probe change,
    // so the host gets an absolute reference value for the trace.
    assign w_en_rise   = la_en & ~armed_q;
    assign w_push      = w_en_rise | (la_en & armed_q & (la_probe != prev_probe_q));
    // Delta reports cycles elapsed since the previous record, hence +1
    assign w_rec_delta = w_en_rise ? '0 : delta_sat_inc(delta_q);
    assign w_pop       = la_as_tvalid & as_la_tready;
    assign w_drop      = w_push & w_full & ~w_pop;

    // Disabling capture closes the frame on the last buffered word
    assign w_tlast = la_as_tvalid &
                     ((frame_cnt_q == FCNT_LAST) | (~la_en & (w_level == LVL_ONE)));

    // Assemble the record word
    always_comb begin
        w_rec = '0;
        w_rec[pPROBE_WIDTH-1:0]              = la_probe;
        w_rec[DELTA_OFFSET +: DELTA_WIDTH]   = w_rec_delta;
    end

    la_rec_fifo #(
        .pWIDTH (pDATA_WIDTH),
        .pDEPTH (pFIFO_DEPTH)
    ) u_fifo (
        .clk          (axis_clk),
        .rst          (axis_rst),
        .push_i       (w_push),
        .data_i       (w_rec),
        .pop_i        (w_pop),
        .data_o       (w_head),
        .level_o      (w_level),
        .level_next_o (w_level_next),
        .full_o       (w_full),
        .empty_o      (w_empty)
    );

    // Next-state logic for capture, delta, framing, overflow and priority
    always_comb begin
        armed_d     = la_en;
        delta_d     = delta_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;
        drop_cnt_d  = drop_cnt_q;
        hpri_d      = (w_level_next >= HPRI_LVL);

        if (!la_en) begin
            delta_d = '0;
        end else if (w_push) begin
            delta_d = '0;
        end else begin
            delta_d = delta_sat_inc(delta_q);
        end

        if (w_pop) begin
            frame_cnt_d = w_tlast ? '0 : frame_cnt_q + 1'b1;
        end

        // A new enable starts a fresh overflow window
        if (w_en_rise) begin
            ovf_d      = w_drop;
            drop_cnt_d = {7'd0, w_drop};
        end else if (w_drop) begin
            ovf_d      = 1'b1;
            drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
        end
    end

    // State registers
    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            armed_q      <= 1'b0;
            prev_probe_q <= '0;
            delta_q      <= '0;
            frame_cnt_q  <= '0;
            ovf_q        <= 1'b0;
            drop_cnt_q   <= '0;
            hpri_q       <= 1'b0;
        end else begin
            armed_q      <= armed_d;
            prev_probe_q <= la_probe;
            delta_q      <= delta_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_q        <= ovf_d;
            drop_cnt_q   <= drop_cnt_d;
            hpri_q       <= hpri_d;
        end
    end

    assign la_as_tdata  = w_head;
    assign la_as_tvalid = ~w_empty;
    assign la_as_tlast  = w_tlast;
    assign la_as_tstrb  = '1;
    assign la_as_tkeep  = '1;
    assign la_as_tuser  = TUSER_LA;
    assign la_hpri_req  = hpri_q;
    assign la_ovf       = ovf_q;
    assign la_drop_cnt  = drop_cnt_q;

endmodule : la_axis_capture
`default_nettype wire

// File: tb/tb_la_axis_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_la_axis_capture
//  Purpose  : Directed self-checking bench for la_axis_capture.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_la_axis_capture;

    logic        axis_clk = 1'b0;
    logic        axis_rst;
    logic        la_en;
    logic [23:0] la_probe;
    logic [31:0] la_as_tdata;
    logic [3:0]  la_as_tstrb;
    logic [3:0]  la_as_tkeep;
    logic        la_as_tlast;
    logic        la_as_tvalid;
    logic [1:0]  la_as_tuser;
    logic        la_hpri_req;
    logic        as_la_tready;
    logic        la_ovf;
    logic [7:0]  la_drop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Accepted words: {tlast, tdata}
    logic [32:0] q_words[$];

    la_axis_capture dut (
        .axis_clk     (axis_clk),
        .axis_rst     (axis_rst),
        .la_en        (la_en),
        .la_probe     (la_probe),
        .la_as_tdata  (la_as_tdata),
        .la_as_tstrb  (la_as_tstrb),
        .la_as_tkeep  (la_as_tkeep),
        .la_as_tlast  (la_as_tlast),
        .la_as_tvalid (la_as_tvalid),
        .la_as_tuser  (la_as_tuser),
        .la_hpri_req  (la_hpri_req),
        .as_la_tready (as_la_tready),
        .la_ovf       (la_ovf),
        .la_drop_cnt  (la_drop_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    // Collect handshaken words away from the active edge
    always @(negedge axis_clk) begin
        if (!axis_rst && la_as_tvalid && as_la_tready)
            q_words.push_back({la_as_tlast, la_as_tdata});
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [32:0] word_at(input int j);
        if (j < q_words.size()) return q_words[j];
        return 'x;
    endfunction

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_reset();
        axis_rst     = 1'b1;
        la_en        = 1'b0;
        la_probe     = '0;
        as_la_tready = 1'b0;
        tick();
        tick();
        axis_rst = 1'b0;
        tick();
        q_words.delete();
    endtask

    initial begin
        do_reset();

        // ---- reset state ----
        check("rst_tvalid", la_as_tvalid, 0);
        check("rst_tlast",  la_as_tlast,  0);
        check("rst_tdata",  la_as_tdata,  0);
        check("rst_hpri",   la_hpri_req,  0);
        check("rst_ovf",    la_ovf,       0);
        check("rst_drop",   la_drop_cnt,  0);
        check("rst_tstrb",  la_as_tstrb,  4'hF);
        check("rst_tkeep",  la_as_tkeep,  4'hF);
        check("rst_tuser",  la_as_tuser,  0);

        // ---- static probe: one word, tlast when enable drops ----
        la_en = 1'b1;
        la_probe = 24'h000000;
        repeat (3) tick();
        check("t1_tvalid", la_as_tvalid, 1);
        check("t1_tdata",  la_as_tdata,  32'h00000000);
        check("t1_tlast_en", la_as_tlast, 0);
        la_en = 1'b0;
        #1;
        check("t1_tlast_dis", la_as_tlast, 1);
        as_la_tready = 1'b1;
        repeat (4) tick();
        check("t1_count", q_words.size(), 1);
        check("t1_word",  word_at(0), {1'b1, 32'h00000000});
        check("t1_idle",  la_as_tvalid, 0);

        // ---- deltas 0, 3, saturated ----
        do_reset();
        as_la_tready = 1'b1;
        la_en = 1'b1;
        la_probe = 24'h111111;
        tick();                     // edge 0
        tick(); tick();             // edges 1,2
        la_probe = 24'h222222;
        tick();                     // edge 3
        repeat (296) tick();        // edges 4..299
        la_probe = 24'h333333;
        tick();                     // edge 300
        repeat (3) tick();
        check("t2_count", q_words.size(), 3);
        check("t2_w0", word_at(0), {1'b0, 32'h00111111});
        check("t2_w1", word_at(1), {1'b0, 32'h03222222});
        check("t2_w2", word_at(2), {1'b0, 32'hFF333333});

        // ---- back-pressure, overflow, priority ----
        do_reset();
        la_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            la_probe = 24'hA00000 + 24'(i);
            tick();
            if (i == 4) check("t3_hpri_lvl5", la_hpri_req, 0);
            if (i == 5) check("t3_hpri_lvl6", la_hpri_req, 1);
        end
        check("t3_ovf",  la_ovf,      1);
        check("t3_drop", la_drop_cnt, 2);
        check("t3_hpri", la_hpri_req, 1);
        check("t3_head", la_as_tdata, 32'h00A00000);
        as_la_tready = 1'b1;
        repeat (12) tick();
        check("t3_count", q_words.size(), 8);
        for (int j = 0; j < 8; j++)
            check($sformatf("t3_w%0d", j), word_at(j),
                  {1'b0, (j == 0) ? 8'h00 : 8'h01, 24'hA00000 + 24'(j)});
        check("t3_hpri_drained", la_hpri_req, 0);

        // ---- continuous change, framing ----
        do_reset();
        as_la_tready = 1'b1;
        la_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            la_probe = 24'(i + 1);
            tick();
        end
        la_en = 1'b0;
        repeat (5) tick();
        check("t4_count", q_words.size(), 40);
        for (int j = 0; j < 40; j++)
            check($sformatf("t4_w%0d", j), word_at(j),
                  {(j == 15 || j == 31 || j == 39), (j == 0) ? 8'h00 : 8'h01, 24'(j + 1)});
        check("t4_drop", la_drop_cnt, 0);
        check("t4_ovf",  la_ovf,      0);

        // ---- full FIFO with simultaneous push and pop ----
        do_reset();
        la_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            la_probe = 24'hB00000 + 24'(i);
            tick();
        end
        check("t5_hpri_full", la_hpri_req, 1);
        check("t5_ovf_full",  la_ovf,      0);
        la_probe = 24'hB00008;
        as_la_tready = 1'b1;
        tick();
        as_la_tready = 1'b0;
        check("t5_ovf_pp",  la_ovf,      0);
        check("t5_drop_pp", la_drop_cnt, 0);
        la_probe = 24'hB00009;
        tick();
        check("t5_ovf_still_full",  la_ovf,      1);
        check("t5_drop_still_full", la_drop_cnt, 1);
        as_la_tready = 1'b1;
        repeat (12) tick();
        check("t5_count", q_words.size(), 9);
        check("t5_w0", word_at(0), {1'b0, 32'h00B00000});
        check("t5_w1", word_at(1), {1'b0, 32'h01B00001});
        check("t5_w8", word_at(8), {1'b0, 32'h01B00008});

        // ---- async reset mid-frame, fresh frame afterwards ----
        do_reset();
        as_la_tready = 1'b1;
        la_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            la_probe = 24'hC00000 + 24'(i);
            tick();
        end
        as_la_tready = 1'b0;
        for (int i = 3; i < 7; i++) begin
            la_probe = 24'hC00000 + 24'(i);
            tick();
        end
        check("t6_pre_tvalid", la_as_tvalid, 1);
        axis_rst = 1'b1;
        #1;
        check("t6_async_tvalid", la_as_tvalid, 0);
        check("t6_async_tdata",  la_as_tdata,  0);
        la_en = 1'b0;
        tick();
        tick();
        axis_rst = 1'b0;
        tick();
        q_words.delete();
        as_la_tready = 1'b1;
        la_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            la_probe = 24'hD00000 + 24'(i);
            tick();
        end
        la_en = 1'b0;
        repeat (4) tick();
        check("t6_count",   q_words.size(), 20);
        check("t6_w0",      word_at(0), {1'b0, 32'h00D00000});
        check("t6_w13_last", word_at(13) >> 32, 0);
        check("t6_w15_last", word_at(15) >> 32, 1);
        check("t6_w19_last", word_at(19) >> 32, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_la_axis_capture
`default_nettype wire
